// File: rtl/shift_ser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state
// encoding, default word geometry and the dropped-word counter ceiling.
package shift_ser_pkg;

  localparam int SER_WIDTH   = 16;
  localparam int SER_LOG2    = 4;
  localparam int OVF_CNT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAD     = 2'd2
  } ser_state_t;

endpackage

// File: rtl/shift_deserializer_out_reg.sv
// Output holding register with valid/ready handshake for the deserializer.
// A completed word is loaded when the register is empty or being drained in
// the same cycle; otherwise the new word is dropped and ovf_o pulses.
// Optional feature: define SHIFT_DESER_OVF_CNT_EN to build a saturating
// dropped-word counter; without it ovf_cnt_o is tied to zero.
module deser_out_reg
  import shift_ser_pkg::*;
#(
  parameter int TO = SER_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [TO-1:0] word_i,
  input  logic          ready_i,
  output logic [TO-1:0] data_o,
  output logic          valid_o,
  output logic          ovf_o,
  output logic [7:0]    ovf_cnt_o
);

  logic [TO-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  // Load, hold, drain or drop decision for the holding register.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    if (load_i) begin
      if (!valid_q || ready_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state and the registered overflow pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

`ifdef SHIFT_DESER_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Count each dropped word, sticking at the ceiling instead of wrapping.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_d && (ovf_cnt_q != 8'(OVF_CNT_MAX))) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // Dropped-word counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = 8'h00;
`endif

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer: collects TO bits MSB first while valid_i
// is high, skips trailing pad bits, and hands the word to an output register
// with a valid/ready handshake. Short frames pulse frame_err_o.
// Optional feature: define SHIFT_DESER_OVF_CNT_EN to enable the saturating
// dropped-word counter on ovf_cnt_o.
module shift_deserializer
  import shift_ser_pkg::*;
#(
  parameter int TO     = SER_WIDTH,
  parameter int LOG2TO = SER_LOG2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [TO-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          frame_err_o,
  output logic          ovf_o,
  output logic [7:0]    ovf_cnt_o
);

  localparam logic [LOG2TO:0] CNT_ONE  = (LOG2TO+1)'(1);
  localparam logic [LOG2TO:0] CNT_FULL = (LOG2TO+1)'(TO);

  // The shift register keeps only the first TO-1 bits; the TO-th bit is
  // taken straight from data_i when the word completes.
  ser_state_t      state_q, state_d;
  logic [TO-2:0]   shreg_q, shreg_d;
  logic [LOG2TO:0] cnt_q, cnt_d;
  logic            frame_err_q, frame_err_d;
  logic [TO-1:0]   shift_word;
  logic [LOG2TO:0] cnt_inc;
  logic            word_done;

  assign shift_word = {shreg_q, data_i};
  assign cnt_inc    = cnt_q + CNT_ONE;

  // Frame FSM: next state, shift register, bit count and error pulse.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          shreg_d    = '0;
          shreg_d[0] = data_i;
          cnt_d      = CNT_ONE;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (valid_i) begin
          shreg_d = shift_word[TO-2:0];
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_FULL) begin
            word_done = 1'b1;
            state_d   = PAD;
          end
        end else begin
          shreg_d     = '0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      PAD: begin
        if (!valid_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Frame FSM, shift register, counter and error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;
  assign ready_o     = (state_q == IDLE) && (!valid_o || ready_i);

  deser_out_reg #(
    .TO (TO)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (word_done),
    .word_i    (shift_word),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ovf_o     (ovf_o),
    .ovf_cnt_o (ovf_cnt_o)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer at the default 16-bit width.
// Expected ovf_cnt_o values follow SHIFT_DESER_OVF_CNT_EN.
module tb_shift_deserializer;

  logic        clk;
  logic        reset_n;
  logic        data_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        frame_err_o;
  logic        ovf_o;
  logic [7:0]  ovf_cnt_o;

  int vectors;
  int miscompares;
  int fe_pulses;
  int ovf_pulses;
  logic [15:0] last_word;

`ifdef SHIFT_DESER_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  shift_deserializer #(
    .TO     (16),
    .LOG2TO (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .ovf_o       (ovf_o),
    .ovf_cnt_o   (ovf_cnt_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle 1 ns past the edge and tally pulses.
  task automatic applyStimulus(input logic v, input logic d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk);
    #1;
    if (frame_err_o) fe_pulses++;
    if (ovf_o) ovf_pulses++;
  endtask

  // Shift bits first..first+n-1 of w (MSB first) with valid_i high.
  task automatic sendBits(input logic [15:0] w, input int first, input int n, input logic r);
    for (int i = first; i < first + n; i++) begin
      applyStimulus(1'b1, w[15-i], r);
    end
  endtask

  // One comparison: count it, report and count any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      $error("[TB] %s differs", tag);
    end
  endtask

  // Linear directed sequence covering the deserializer behaviours.
  initial begin
    vectors     = 0;
    miscompares = 0;
    fe_pulses   = 0;
    ovf_pulses  = 0;
    reset_n     = 1'b0;
    data_i      = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_o", 32'(data_o), 32'h0);
    checkOutput("rst_valid_o", 32'(valid_o), 32'h0);
    checkOutput("rst_frame_err_o", 32'(frame_err_o), 32'h0);
    checkOutput("rst_ovf_o", 32'(ovf_o), 32'h0);
    checkOutput("rst_ovf_cnt_o", 32'(ovf_cnt_o), 32'h0);
    checkOutput("rst_ready_o", 32'(ready_o), 32'h1);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Basic frame 0xA5C3 with the downstream always ready.
    sendBits(16'hA5C3, 0, 15, 1'b1);
    checkOutput("a5c3_valid_before_last", 32'(valid_o), 32'h0);
    sendBits(16'hA5C3, 15, 1, 1'b1);
    checkOutput("a5c3_valid", 32'(valid_o), 32'h1);
    checkOutput("a5c3_data", 32'(data_o), 32'hA5C3);
    checkOutput("a5c3_ready_o_in_pad", 32'(ready_o), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("a5c3_valid_after_hs", 32'(valid_o), 32'h0);
    checkOutput("a5c3_data_held", 32'(data_o), 32'hA5C3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_ready_o", 32'(ready_o), 32'h1);

    // Short frame of 7 bits, then a good frame 0x1234.
    sendBits(16'hFFFF, 0, 7, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("short_frame_err", 32'(frame_err_o), 32'h1);
    checkOutput("short_valid", 32'(valid_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("short_err_one_cycle", 32'(frame_err_o), 32'h0);
    sendBits(16'h1234, 0, 16, 1'b1);
    checkOutput("w1234_valid", 32'(valid_o), 32'h1);
    checkOutput("w1234_data", 32'(data_o), 32'h1234);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Two frames with the downstream stalled: the second is dropped.
    sendBits(16'h00FF, 0, 16, 1'b0);
    checkOutput("w00ff_valid", 32'(valid_o), 32'h1);
    checkOutput("w00ff_data", 32'(data_o), 32'h00FF);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stalled_ready_o", 32'(ready_o), 32'h0);
    sendBits(16'hFF00, 0, 16, 1'b0);
    checkOutput("drop_ovf_o", 32'(ovf_o), 32'h1);
    checkOutput("drop_data_kept", 32'(data_o), 32'h00FF);
    checkOutput("drop_valid_kept", 32'(valid_o), 32'h1);
    checkOutput("drop_ovf_cnt", 32'(ovf_cnt_o), CNT_EN ? 32'd1 : 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("drop_ovf_one_cycle", 32'(ovf_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("drain_valid", 32'(valid_o), 32'h0);

    // Completion of 0x2222 in the same cycle 0x1111 is accepted.
    sendBits(16'h1111, 0, 16, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("w1111_data", 32'(data_o), 32'h1111);
    sendBits(16'h2222, 0, 15, 1'b0);
    sendBits(16'h2222, 15, 1, 1'b1);
    checkOutput("refill_valid", 32'(valid_o), 32'h1);
    checkOutput("refill_data", 32'(data_o), 32'h2222);
    checkOutput("refill_no_ovf", 32'(ovf_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("refill_drained", 32'(valid_o), 32'h0);

    // Asynchronous reset in the middle of a frame with a word pending.
    sendBits(16'h5555, 0, 16, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("w5555_pending", 32'(valid_o), 32'h1);
    sendBits(16'hFFFF, 0, 9, 1'b0);
    #2;
    reset_n = 1'b0;
    valid_i = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(data_o), 32'h0);
    checkOutput("async_rst_valid", 32'(valid_o), 32'h0);
    checkOutput("async_rst_ovf_cnt", 32'(ovf_cnt_o), 32'h0);
    checkOutput("async_rst_ready_o", 32'(ready_o), 32'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    sendBits(16'hBEEF, 0, 15, 1'b1);
    checkOutput("beef_valid_before_last", 32'(valid_o), 32'h0);
    sendBits(16'hBEEF, 15, 1, 1'b1);
    checkOutput("beef_valid", 32'(valid_o), 32'h1);
    checkOutput("beef_data", 32'(data_o), 32'hBEEF);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // 260 forced overflows behind a stalled word.
    sendBits(16'h0F0F, 0, 16, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    ovf_pulses = 0;
    for (int k = 1; k <= 260; k++) begin
      last_word = 16'(k);
      sendBits(last_word, 0, 16, 1'b0);
      if (k == 1) checkOutput("sat_cnt_first", 32'(ovf_cnt_o), CNT_EN ? 32'd1 : 32'd0);
      if (k == 254) checkOutput("sat_cnt_254", 32'(ovf_cnt_o), CNT_EN ? 32'd254 : 32'd0);
      if (k == 255) checkOutput("sat_cnt_255", 32'(ovf_cnt_o), CNT_EN ? 32'd255 : 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat_ovf_pulses", 32'(ovf_pulses), 32'd260);
    checkOutput("sat_cnt_final", 32'(ovf_cnt_o), CNT_EN ? 32'd255 : 32'd0);
    checkOutput("sat_data_kept", 32'(data_o), 32'h0F0F);
    checkOutput("total_frame_err_pulses", 32'(fe_pulses), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter TO, default 16, meaning parallel output word width in bits, legal range 2..255.
REQ-002 SHALL have parameter LOG2TO, default 4, meaning ceil(log2(TO)); the bit counter is LOG2TO+1 bits wide.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_i, input, 1, serial bit, MSB first.
REQ-006 SHALL have port valid_i, input, 1, frame qualifier; high on every cycle of a serial frame.
REQ-007 SHALL have port ready_o, output, 1, advisory to upstream: a new frame will not overflow.
REQ-008 SHALL have port data_o, output, TO, assembled parallel word.
REQ-009 SHALL have port valid_o, output, 1, data_o holds an unconsumed word.
REQ-010 SHALL have port ready_i, input, 1, downstream accepts data_o when valid_o and ready_i are both high.
REQ-011 SHALL have port frame_err_o, output, 1, one-cycle pulse on a short frame.
REQ-012 SHALL have port ovf_o, output, 1, one-cycle pulse on a dropped word.
REQ-013 SHALL have port ovf_cnt_o, output, 8, saturating dropped-word count.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, PAD.
REQ-015 IDLE with valid_i high SHALL shift data_i into the shift register LSB, set bit count to 1, and go to COLLECT.
REQ-016 COLLECT with valid_i high SHALL shift {shreg[TO-2:0], data_i} and increment the count.
REQ-017 When the shift makes the count equal TO, the word SHALL be complete and the FSM SHALL go to PAD.
REQ-018 COLLECT with valid_i low before TO bits SHALL discard partial data, pulse frame_err_o, and go to IDLE.
REQ-019 PAD SHALL ignore data_i while valid_i is high; the first bit after TO is trailing pad and never stored.
REQ-020 PAD SHALL go to IDLE on valid_i low; a new frame requires at least one valid_i-low cycle.
REQ-021 On completion, the word SHALL load into the output register and valid_o SHALL rise the cycle after the TO-th bit is sampled (latency 1).
REQ-022 valid_o and data_o SHALL stay stable until the handshake; valid_o falls the cycle after acceptance, unless refilled.
REQ-023 Completion with handshake in the same cycle SHALL load the new word and keep valid_o high.
REQ-024 Completion while valid_o high and ready_i low SHALL drop the new word, keep the old one, and pulse ovf_o.
REQ-025 ready_o SHALL equal (state==IDLE) and (~valid_o or ready_i), combinationally.
REQ-026 Frames SHALL never stall; they are processed regardless of ready_o.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, shift register 0, count 0, data_o 0, valid_o 0, frame_err_o 0, ovf_o 0, ovf_cnt_o 0.
REQ-028 Reset mid-frame SHALL abandon the frame; after release, the next valid_i-high cycle in IDLE starts a new frame.

Configuration
REQ-029 With SHIFT_DESER_OVF_CNT_EN defined, ovf_cnt_o SHALL increment on each ovf_o pulse and saturate at 255.
REQ-030 Without SHIFT_DESER_OVF_CNT_EN, ovf_cnt_o SHALL be constant 0, with no counter register.

Structure
REQ-031 Package shift_ser_pkg SHALL hold the FSM state enum (IDLE, COLLECT, PAD) and defaults SER_WIDTH=16, SER_LOG2=4.
REQ-032 The output register and handshake SHALL be one sub-module, deser_out_reg; FSM, counter and shift register stay in the top.

Verification
REQ-033 TO=16: send 0xA5C3 MSB first over 16 cycles plus 1 pad cycle, ready_i=1 -> valid_o one cycle after the 16th bit, data_o=0xA5C3, handshake for 1 cycle.
REQ-034 Drop valid_i after 7 bits -> frame_err_o pulses once, no valid_o, next frame 0x1234 delivered correctly.
REQ-035 Two frames 0x00FF, 0xFF00 with ready_i=0 -> data_o holds 0x00FF, ovf_o pulses at the second completion; with the macro, ovf_cnt_o=1.
REQ-036 Completion coincident with acceptance of 0x1111 -> valid_o stays high, data_o becomes 0x2222.
REQ-037 reset_n pulsed low at bit 9 -> all outputs 0 immediately; following frame 0xBEEF delivered intact.
REQ-038 With the macro, 260 forced overflows -> ovf_cnt_o saturates at 255; without the macro -> ovf_cnt_o stays 0.
